ice_ram32: RTL and testbench



---
 rtl/ice_ram_pkg.sv | 9 +
 rtl/ice_ram32_core.sv | 45 ++++
 rtl/ice_ram32.sv | 51 +++++
 tb/tb_ice_ram32.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ice_ram_pkg.sv
// rtl/ice_ram_pkg.sv - shared width defaults and word type for the ice_ram32 block RAM
package ice_ram_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/ice_ram32_core.sv
// rtl/ice_ram32_core.sv - r_data storage, per-bit masked write and unregistered read
// Same-address read returns the merged new word only when RAM32_BYPASS_EN is defined.
module ice_ram32_core
    import ice_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] mask_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              we_i,
    input  logic              wclke_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rd_word_o
);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DATA_W-1:0] wr_word;
    logic              wr_en;

    // An X on either enable makes the if() false, so memory is left untouched.
    assign wr_en   = we_i && wclke_i;
    assign wr_word = (wdata_i & ~mask_i) | (r_data[waddr_i] & mask_i);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            r_data[waddr_i] <= wr_word;
        end
    end

`ifdef RAM32_BYPASS_EN
    always_comb begin
        rd_word_o = r_data[raddr_i];
        if (wr_en && (waddr_i == raddr_i)) begin
            rd_word_o = wr_word;
        end
    end
`else
    assign rd_word_o = r_data[raddr_i];
`endif

endmodule

// File: rtl/ice_ram32.sv
// rtl/ice_ram32.sv - 256x32 simple dual-port RAM, iCE40 style, registered read (option: RAM32_BYPASS_EN)
module ice_ram32
    import ice_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              gclk,
    input  logic              grst,
    output logic [DATA_W-1:0] RDATA,
    input  logic [ADDR_W-1:0] RADDR,
    input  logic              RE,
    input  logic              RCLKE,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [DATA_W-1:0] MASK,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic              WE,
    input  logic              WCLKE
);

    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Storage has no reset, so writes keep working while grst is low.
    ice_ram32_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) ram (
        .clk_i     (gclk),
        .wdata_i   (WDATA),
        .mask_i    (MASK),
        .waddr_i   (WADDR),
        .we_i      (WE),
        .wclke_i   (WCLKE),
        .raddr_i   (RADDR),
        .rd_word_o (rdata_d)
    );

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            rdata_q <= '0;
        end else if (RE && RCLKE) begin
            rdata_q <= rdata_d;
        end
    end

    assign RDATA = rdata_q;

endmodule

// File: tb/tb_ice_ram32.sv
// tb/tb_ice_ram32.sv - directed self-checking bench for ice_ram32, three copies sharing one write stream
module tb_ice_ram32;
    import ice_ram_pkg::*;

    logic        gclk;
    logic        grst;
    logic [7:0]  raddr [3];
    word_t       rdata [3];
    logic        re;
    logic        rclke;
    word_t       wdata;
    word_t       mask;
    logic [7:0]  waddr;
    logic        we;
    logic        wclke;

    int checks;
    int failures;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ice_ram32 u_dut (
            .gclk  (gclk),
            .grst  (grst),
            .RDATA (rdata[g]),
            .RADDR (raddr[g]),
            .RE    (re),
            .RCLKE (rclke),
            .WDATA (wdata),
            .MASK  (mask),
            .WADDR (waddr),
            .WE    (we),
            .WCLKE (wclke)
        );
    end

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs are driven just after the falling edge; one rising edge is applied,
    // outputs are sampled at the next falling edge.
    task automatic cycle();
        @(posedge gclk);
        @(negedge gclk);
    endtask

    task automatic wr(input logic [7:0] a, input word_t d, input word_t m);
        waddr = a; wdata = d; mask = m; we = 1'b1; wclke = 1'b1;
        cycle();
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        raddr[0] = a; raddr[1] = a; raddr[2] = a;
        re = 1'b1; rclke = 1'b1;
        cycle();
        re = 1'b0; rclke = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        grst = 1'b0;
        re = 1'b0; rclke = 1'b0; we = 1'b0; wclke = 1'b0;
        wdata = '0; mask = '0; waddr = '0;
        raddr[0] = '0; raddr[1] = '0; raddr[2] = '0;
        repeat (2) @(negedge gclk);
        check("reset_rdata", rdata[0], 32'h0);
        grst = 1'b1;
        @(negedge gclk);

        wr(8'd5, 32'hDEADBEEF, 32'h0);
        rd(8'd5);
        check("basic_rw", rdata[0], 32'hDEADBEEF);

        wr(8'd5, 32'h12345678, 32'hFFFF0000);
        rd(8'd5);
        check("masked_write", rdata[0], 32'hDEAD5678);

        waddr = 8'd5; wdata = 32'h0; mask = 32'h0; we = 1'b1; wclke = 1'b0;
        cycle();
        we = 1'b0;
        rd(8'd5);
        check("wclke_gate", rdata[0], 32'hDEAD5678);

        wr(8'd6, 32'h11112222, 32'h0);
        raddr[0] = 8'd6; re = 1'b0; rclke = 1'b1;
        cycle();
        check("re_gate", rdata[0], 32'hDEAD5678);
        re = 1'b1; rclke = 1'b0;
        cycle();
        check("rclke_gate", rdata[0], 32'hDEAD5678);
        rd(8'd6);
        check("read_addr6", rdata[0], 32'h11112222);

        wr(8'd6, 32'hFFFFFFFF, 32'hFFFFFFFF);
        rd(8'd6);
        check("mask_all_ones", rdata[0], 32'h11112222);

        wr(8'd7, 32'hAAAAAAAA, 32'h0);
        raddr[0] = 8'd7; re = 1'b1; rclke = 1'b1;
        waddr = 8'd7; wdata = 32'h55555555; mask = 32'h0; we = 1'b1; wclke = 1'b1;
        cycle();
        we = 1'b0; re = 1'b0; rclke = 1'b0;
`ifdef RAM32_BYPASS_EN
        check("collision", rdata[0], 32'h55555555);
`else
        check("collision", rdata[0], 32'hAAAAAAAA);
`endif
        rd(8'd7);
        check("collision_after", rdata[0], 32'h55555555);

        wr(8'd255, 32'hCAFEF00D, 32'h0);
        rd(8'd255);
        check("top_addr", rdata[0], 32'hCAFEF00D);

        wr(8'd0, 32'hFFFFFFFF, 32'h0);
        wr(8'd31, 32'h1, 32'h0);
        rd(8'd6);
        check("pre_reset", rdata[0], 32'h11112222);
        #2 grst = 1'b0;
        #1 check("async_reset", rdata[0], 32'h0);
        @(negedge gclk);
        raddr[0] = 8'd6; re = 1'b1; rclke = 1'b1;
        waddr = 8'd0; wdata = 32'h0; mask = 32'h0; we = 1'b1; wclke = 1'b1;
        cycle();
        we = 1'b0; re = 1'b0; rclke = 1'b0;
        check("held_in_reset", rdata[0], 32'h0);
        grst = 1'b1;
        @(negedge gclk);
        rd(8'd0);
        check("write_in_reset", rdata[0], 32'h0);
        rd(8'd31);
        check("mem_kept", rdata[0], 32'h1);

        wr(8'd1, 32'h00000101, 32'h0);
        wr(8'd2, 32'h00000202, 32'h0);
        wr(8'd3, 32'h00000303, 32'h0);
        raddr[0] = 8'd1; raddr[1] = 8'd2; raddr[2] = 8'd3;
        re = 1'b1; rclke = 1'b1;
        cycle();
        re = 1'b0; rclke = 1'b0;
        check("rf_port0", rdata[0], 32'h00000101);
        check("rf_port1", rdata[1], 32'h00000202);
        check("rf_port2", rdata[2], 32'h00000303);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
